// File: rtl/ag_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// ag_uart_cmd_rx
// UART 8N1 receiver plus 3-byte command-frame decoder (sync, cmd, checksum).
// A good frame updates the held override / crop-profile registers.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          global enable; when low, all state and outputs hold and
//                strobes read as 0
//   uart_rx      asynchronous serial input, idle high
//   rx_data      last correctly framed byte
//   rx_valid     1-cycle strobe, rx_data updated
//   frame_err    1-cycle strobe, stop bit sampled low
//   cmd_valid    1-cycle strobe, good frame applied
//   cmd_err      1-cycle strobe, bad checksum / reserved bits / abort
//   cmd_override held override bit from the last good frame
//   cmd_crop     held crop profile from the last good frame
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ag_uart_cmd_rx #(
    parameter int         CLKS_PER_BIT = 217,
    parameter int         TIMEOUT_CLKS = 25000,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter logic [7:0] CHK_KEY      = 8'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_valid,
    output logic       cmd_err,
    output logic       cmd_override,
    output logic [1:0] cmd_crop
);
    localparam int BCNT_W = $clog2(CLKS_PER_BIT);
    localparam int TMR_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BCNT_W-1:0] HALF_LAST = BCNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {P_HUNT, P_CMD, P_CHK} p_state_t;

    logic              r_sync1, r_sync2;
    rx_state_t         r_rx_state, w_rx_state_nxt;
    logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;
    logic [2:0]        r_bidx, w_bidx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              w_byte_ok, w_byte_bad;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid, r_frame_err;

    p_state_t          r_p_state, w_p_state_nxt;
    logic [7:0]        r_cmd_byte, w_cmd_byte_nxt;
    logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
    logic              w_good, w_bad;
    logic              r_cmd_valid, r_cmd_err, r_cmd_override;
    logic [1:0]        r_cmd_crop;

    // Receiver next-state: bit timing, start-bit validation, shift and stop check
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_bcnt_nxt     = r_bcnt;
        w_bidx_nxt     = r_bidx;
        w_shift_nxt    = r_shift;
        w_byte_ok      = 1'b0;
        w_byte_bad     = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_bcnt_nxt = '0;
                if (!r_sync2) w_rx_state_nxt = RX_START;
                else          w_rx_state_nxt = RX_IDLE;
            end
            RX_START: begin
                // Mid-start-bit sample: a line already back high was a glitch
                if (r_bcnt == HALF_LAST) begin
                    w_bcnt_nxt = '0;
                    w_bidx_nxt = 3'd0;
                    if (!r_sync2) w_rx_state_nxt = RX_DATA;
                    else          w_rx_state_nxt = RX_IDLE;
                end else begin
                    w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_bcnt == BIT_LAST) begin
                    w_bcnt_nxt  = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    if (r_bidx == 3'd7) w_rx_state_nxt = RX_STOP;
                    else                w_bidx_nxt     = r_bidx + 3'd1;
                end else begin
                    w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_bcnt == BIT_LAST) begin
                    w_bcnt_nxt = '0;
                    if (r_sync2) begin
                        w_byte_ok      = 1'b1;
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_byte_bad     = 1'b1;
                        w_rx_state_nxt = RX_BREAK;
                    end
                end else begin
                    w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                end
            end
            RX_BREAK: begin
                // Held-low line: wait for idle before hunting a new start bit
                if (r_sync2) w_rx_state_nxt = RX_IDLE;
                else         w_rx_state_nxt = RX_BREAK;
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
                w_bcnt_nxt     = '0;
            end
        endcase
    end

    // Parser next-state: frame sequencing, checksum check and inter-byte timeout
    always_comb begin
        w_p_state_nxt  = r_p_state;
        w_cmd_byte_nxt = r_cmd_byte;
        w_tmr_nxt      = r_tmr;
        w_good         = 1'b0;
        w_bad          = 1'b0;
        if (r_p_state == P_HUNT) begin
            w_tmr_nxt = '0;
            if (r_rx_valid && (r_rx_data == SYNC_BYTE)) w_p_state_nxt = P_CMD;
            else                                        w_p_state_nxt = P_HUNT;
        end else if (r_frame_err) begin
            w_p_state_nxt = P_HUNT;
            w_tmr_nxt     = '0;
            w_bad         = 1'b1;
        end else if (r_rx_valid) begin
            w_tmr_nxt = '0;
            case (r_p_state)
                P_CMD: begin
                    // A second sync byte here is command data, no resync
                    w_cmd_byte_nxt = r_rx_data;
                    w_p_state_nxt  = P_CHK;
                end
                P_CHK: begin
                    w_p_state_nxt = P_HUNT;
                    if ((r_rx_data == (r_cmd_byte ^ CHK_KEY)) && (r_cmd_byte[7:3] == 5'd0))
                        w_good = 1'b1;
                    else
                        w_bad  = 1'b1;
                end
                default: w_p_state_nxt = P_HUNT;
            endcase
        end else if (r_tmr == TMR_MAX) begin
            w_p_state_nxt = P_HUNT;
            w_tmr_nxt     = '0;
            w_bad         = 1'b1;
        end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
        end
    end

    // State and output registers; everything freezes while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1        <= 1'b1;
            r_sync2        <= 1'b1;
            r_rx_state     <= RX_IDLE;
            r_bcnt         <= '0;
            r_bidx         <= 3'd0;
            r_shift        <= 8'd0;
            r_rx_data      <= 8'd0;
            r_rx_valid     <= 1'b0;
            r_frame_err    <= 1'b0;
            r_p_state      <= P_HUNT;
            r_cmd_byte     <= 8'd0;
            r_tmr          <= '0;
            r_cmd_valid    <= 1'b0;
            r_cmd_err      <= 1'b0;
            r_cmd_override <= 1'b0;
            r_cmd_crop     <= 2'd0;
        end else if (ena) begin
            r_sync1     <= uart_rx;
            r_sync2     <= r_sync1;
            r_rx_state  <= w_rx_state_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_bidx      <= w_bidx_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_valid  <= w_byte_ok;
            r_frame_err <= w_byte_bad;
            if (w_byte_ok) r_rx_data <= r_shift;
            r_p_state   <= w_p_state_nxt;
            r_cmd_byte  <= w_cmd_byte_nxt;
            r_tmr       <= w_tmr_nxt;
            r_cmd_valid <= w_good;
            r_cmd_err   <= w_bad;
            if (w_good) begin
                r_cmd_override <= r_cmd_byte[0];
                r_cmd_crop     <= r_cmd_byte[2:1];
            end
        end
    end

    // Strobes are held across an ena-low stretch (so the parser does not lose
    // a byte) but masked so they only show once the block is running again.
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid  & ena;
    assign frame_err    = r_frame_err & ena;
    assign cmd_valid    = r_cmd_valid & ena;
    assign cmd_err      = r_cmd_err   & ena;
    assign cmd_override = r_cmd_override;
    assign cmd_crop     = r_cmd_crop;
endmodule

// File: tb/tb_ag_uart_cmd_rx.sv
`timescale 1ns/1ps
module tb_ag_uart_cmd_rx;
    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, cmd_valid, cmd_err, cmd_override;
    logic [1:0] cmd_crop;

    ag_uart_cmd_rx dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .uart_rx(uart_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .cmd_valid(cmd_valid), .cmd_err(cmd_err),
        .cmd_override(cmd_override), .cmd_crop(cmd_crop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic       ov;
        logic [1:0] crop;
    } cmd_ev_t;

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic       exp_err;
        logic       exp_ov;
        logic [1:0] exp_crop;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rxv = 0, n_ferr = 0, n_cv = 0, n_ce = 0;
    logic [7:0] q_rx[$];
    cmd_ev_t    q_cmd[$];
    vec_t       vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: strobe with value %0h, expected no strobe", name, act);
    endtask

    // Scoreboard monitor: pops expectations as the DUT strobes
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                n_rxv++;
                if (q_rx.size() == 0) unexpected("rx_valid_unexpected", {24'd0, rx_data});
                else                  chk("rx_data", {24'd0, rx_data}, {24'd0, q_rx.pop_front()});
            end
            if (frame_err) n_ferr++;
            if (cmd_valid && cmd_err) unexpected("cmd_valid_and_err", 32'd3);
            if (cmd_valid) n_cv++;
            if (cmd_err)   n_ce++;
            if (cmd_valid || cmd_err) begin
                if (q_cmd.size() == 0) begin
                    unexpected("cmd_strobe_unexpected", {30'd0, cmd_valid, cmd_err});
                end else begin
                    cmd_ev_t ev;
                    ev = q_cmd.pop_front();
                    chk("cmd_err_kind", {31'd0, cmd_err}, {31'd0, ev.is_err});
                    chk("cmd_override", {31'd0, cmd_override}, {31'd0, ev.ov});
                    chk("cmd_crop", {30'd0, cmd_crop}, {30'd0, ev.crop});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b);
        q_rx.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic wait_drain(input string name, input int budget, output int waited);
        waited = 0;
        while (((q_rx.size() + q_cmd.size()) != 0) && (waited < budget)) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_pending"}, q_rx.size() + q_cmd.size(), 32'd0);
    endtask

    task automatic apply_frame(input string name, input vec_t v);
        int w;
        cmd_ev_t ev;
        ev.is_err = v.exp_err;
        ev.ov     = v.exp_ov;
        ev.crop   = v.exp_crop;
        q_cmd.push_back(ev);
        send_rx(v.b0);
        send_rx(v.b1);
        send_rx(v.b2);
        wait_drain(name, 50, w);
        chk({name, "_held_ov"}, {31'd0, cmd_override}, {31'd0, v.exp_ov});
        chk({name, "_held_crop"}, {30'd0, cmd_crop}, {30'd0, v.exp_crop});
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {rx_data, rx_valid, frame_err, cmd_valid, cmd_err, cmd_override, cmd_crop}, 32'd0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, rxv0, ferr0, cv0, ce0;
        vec_t v;
        // b0, b1, b2, error?, held override and crop afterwards
        vecs[0] = '{8'hA5, 8'h05, 8'h5F, 1'b0, 1'b1, 2'b10};
        vecs[1] = '{8'hA5, 8'h03, 8'h00, 1'b1, 1'b1, 2'b10};
        vecs[2] = '{8'hA5, 8'h08, 8'h52, 1'b1, 1'b1, 2'b10};

        repeat (5) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;

        // Line activity while disabled must be ignored entirely
        uart_rx = 1'b0;
        repeat (300) @(negedge clk);
        uart_rx = 1'b1;
        repeat (10) @(negedge clk);
        ena = 1'b1;
        repeat (20) @(negedge clk);
        chk("ena_low_no_rx", n_rxv + n_ferr, 32'd0);

        for (int i = 0; i < 3; i++) begin
            apply_frame($sformatf("vec%0d", i), vecs[i]);
            if (i == 0) begin
                ena = 1'b0;
                repeat (30) @(negedge clk);
                chk("ena_hold_ov", {31'd0, cmd_override}, 32'd1);
                chk("ena_hold_crop", {30'd0, cmd_crop}, 32'd2);
                ena = 1'b1;
            end
        end

        // Short low glitch: start bit rejected
        rxv0 = n_rxv;
        ferr0 = n_ferr;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (50) @(negedge clk);
        uart_rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_no_rx_valid", n_rxv, rxv0);
        chk("glitch_no_frame_err", n_ferr, ferr0);

        // Stop bit forced low: frame_err, rx_data unchanged
        send_byte(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        chk("frame_err_count", n_ferr, ferr0 + 1);
        chk("frame_err_no_rx_valid", n_rxv, rxv0);
        chk("frame_err_rx_data_kept", {24'd0, rx_data}, 32'h52);

        v = '{8'hA5, 8'h02, 8'h58, 1'b0, 1'b0, 2'b01};
        apply_frame("after_break", v);

        // Timeout after sync byte
        q_cmd.push_back('{1'b1, 1'b0, 2'b01});
        send_rx(8'hA5);
        wait_drain("timeout", 30000, w);
        chk("timeout_not_early", {31'd0, (w > 24000)}, 32'd1);
        cv0 = n_cv;
        ce0 = n_ce;
        send_rx(8'h02);
        send_rx(8'h58);
        wait_drain("post_timeout", 50, w);
        chk("post_timeout_no_cmd_valid", n_cv, cv0);
        chk("post_timeout_no_cmd_err", n_ce, ce0);

        // Reset in the middle of a data bit of the second byte
        send_rx(8'hA5);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midframe_reset_outputs");
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        v = '{8'hA5, 8'h01, 8'h5B, 1'b0, 1'b1, 2'b00};
        apply_frame("after_reset", v);

        chk("total_cmd_valid", n_cv, 32'd3);
        chk("total_cmd_err", n_ce, 32'd3);
        chk("total_frame_err", n_ferr, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
